contador_m_updown: RTL and testbench



---
 rtl/contador_pkg.sv | 19 +
 rtl/contador_cmp.sv | 16 +
 rtl/contador_m_updown.sv | 116 +++++++++++
 tb/tb_contador_m_updown.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared counter definitions: direction encodings and effective-modulus helper.
// Latency: none (package only).
// Backpressure: not applicable.
package contador_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // A runtime modulus of 0, or one beyond the synthesised maximum,
   // falls back to the maximum so the counter always has a legal range.
   function automatic logic [31:0] eff_mod(input logic [31:0] m_val,
                                           input logic [31:0] m_max);
      if (m_val == 32'd0 || m_val > m_max) begin
         return m_max;
      end
      return m_val;
   endfunction

endpackage

// File: rtl/contador_cmp.sv
// N-bit equality compare, shareable with the PWM block.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports: a, b (W bits) compared; eq high when a == b.
module contador_cmp #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq
);

   assign eq = (a == b);

endmodule

// File: rtl/contador_m_updown.sv
// Up/down modulo counter with runtime modulus, sync clear/load, compare and wrap pulse.
// Latency: Q and pulso_fim registered (1 cycle); fim, meio, iguala combinational.
// Backpressure: none; every enabled edge counts.
//
// Ports:
//   clock, zera_as_n (async active-low reset), zera_s (sync clear),
//   carrega + D (sync load, clamped to T), conta (enable), desce (0 up / 1 down),
//   m_val (runtime modulus, 0 or >M selects M), cmp (compare value),
//   Q (count), fim (terminal for direction), meio (half-way), iguala (Q==cmp),
//   pulso_fim (one-cycle pulse after a wrap).
// Build option: define CONTADOR_M_UPDOWN_SATURA_EN for saturating (non-wrapping) mode.
module contador_m_updown
   import contador_pkg::*;
#(
   parameter int M = 200,
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] D,
   input  logic         conta,
   input  logic         desce,
   input  logic [N-1:0] m_val,
   input  logic [N-1:0] cmp,
   output logic [N-1:0] Q,
   output logic         fim,
   output logic         meio,
   output logic         iguala,
   output logic         pulso_fim
);

   localparam logic [N:0] ONE_X = {{N{1'b0}}, 1'b1};

   logic [N-1:0] cnt_q, cnt_d;
   logic         pulso_q, pulso_d;

   // All arithmetic is carried at N+1 bits so Me = 2^N fits and nothing wraps.
   logic [N:0] me;
   logic [N:0] t;
   logic [N:0] me_half;
   logic [N:0] q_ext;
   logic [N:0] d_ext;
   logic [N:0] q_inc;
   logic [N:0] q_dec;

   assign me      = (N+1)'(eff_mod(32'(m_val), 32'(M)));
   assign t       = me - ONE_X;
   assign me_half = me >> 1;
   assign q_ext   = {1'b0, cnt_q};
   assign d_ext   = {1'b0, D};
   assign q_inc   = q_ext + ONE_X;
   assign q_dec   = q_ext - ONE_X;

   always_comb begin
      cnt_d   = cnt_q;
      pulso_d = 1'b0;
      if (zera_s) begin
         cnt_d = '0;
      end else if (carrega) begin
         cnt_d = (d_ext > t) ? N'(t) : D;
      end else if (conta) begin
         if (desce == DIR_UP) begin
            // >= rather than == so a Q stranded above a shrunk T recovers.
            if (q_ext >= t) begin
`ifdef CONTADOR_M_UPDOWN_SATURA_EN
               cnt_d = N'(t);
`else
               cnt_d   = '0;
               pulso_d = 1'b1;
`endif
            end else begin
               cnt_d = N'(q_inc);
            end
         end else begin
            if (q_ext == '0) begin
`ifdef CONTADOR_M_UPDOWN_SATURA_EN
               cnt_d = '0;
`else
               cnt_d   = N'(t);
               pulso_d = 1'b1;
`endif
            end else if (q_ext > t) begin
               // Modulus shrank under us: snap to the new top, not a wrap.
               cnt_d = N'(t);
            end else begin
               cnt_d = N'(q_dec);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         cnt_q   <= '0;
         pulso_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulso_q <= pulso_d;
      end
   end

   assign Q         = cnt_q;
   assign pulso_fim = pulso_q;
   assign fim       = (desce == DIR_DOWN) ? (q_ext == '0) : (q_ext >= t);
   // Add to Q instead of subtracting from Me so Me=1 cannot underflow.
   assign meio      = (q_inc >= me_half);

   contador_cmp #(.W(N)) u_cmp (
      .a  (cnt_q),
      .b  (cmp),
      .eq (iguala)
   );

endmodule

// File: tb/tb_contador_m_updown.sv
module tb_contador_m_updown;

   localparam int M = 200;
   localparam int N = 8;

   logic         clock;
   logic         zera_as_n;
   logic         zera_s;
   logic         carrega;
   logic [N-1:0] D;
   logic         conta;
   logic         desce;
   logic [N-1:0] m_val;
   logic [N-1:0] cmp;
   logic [N-1:0] Q;
   logic         fim;
   logic         meio;
   logic         iguala;
   logic         pulso_fim;

   int assertions = 0;
   int failures   = 0;

   contador_m_updown #(.M(M), .N(N)) dut (
      .clock     (clock),
      .zera_as_n (zera_as_n),
      .zera_s    (zera_s),
      .carrega   (carrega),
      .D         (D),
      .conta     (conta),
      .desce     (desce),
      .m_val     (m_val),
      .cmp       (cmp),
      .Q         (Q),
      .fim       (fim),
      .meio      (meio),
      .iguala    (iguala),
      .pulso_fim (pulso_fim)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One rising edge; returns on the following falling edge where outputs are stable.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      zera_s  = 1'b0;
      carrega = 1'b0;
      conta   = 1'b0;
   endtask

   task automatic test_reset();
      zera_as_n = 1'b0;
      zera_s    = 1'b0;
      carrega   = 1'b0;
      D         = '0;
      conta     = 1'b1;
      desce     = 1'b0;
      m_val     = '0;
      cmp       = 8'd255;
      repeat (3) step();
      assertions++;
      if (Q !== 8'd0) begin
         failures++;
         $display("FAIL reset_q: got %0d expected 0", Q);
      end
      assertions++;
      if (pulso_fim !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulse: got %0b expected 0", pulso_fim);
      end
      conta     = 1'b0;
      zera_as_n = 1'b1;
      step();
   endtask

   task automatic test_up_wrap();
      int pulses;
      logic exp_p;
      pulses = 0;
      m_val  = '0;
      desce  = 1'b0;
      for (int i = 0; i < 200; i++) begin
         assertions++;
         if (Q !== 8'(i)) begin
            failures++;
            $display("FAIL up_q: step %0d got %0d expected %0d", i, Q, i);
         end
         assertions++;
         if (fim !== (i == 199)) begin
            failures++;
            $display("FAIL up_fim: Q=%0d got %0b expected %0b", i, fim, (i == 199));
         end
         conta = 1'b1;
         step();
         exp_p = (i == 199);
         if (pulso_fim === 1'b1) pulses++;
         assertions++;
         if (pulso_fim !== exp_p) begin
            failures++;
            $display("FAIL up_pulse: step %0d got %0b expected %0b", i, pulso_fim, exp_p);
         end
      end
      assertions++;
      if (Q !== 8'd0) begin
         failures++;
         $display("FAIL up_wrap_q: got %0d expected 0", Q);
      end
      assertions++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL up_pulse_count: got %0d expected 1", pulses);
      end
      conta = 1'b0;
      step();
      assertions++;
      if (pulso_fim !== 1'b0) begin
         failures++;
         $display("FAIL up_pulse_width: got %0b expected 0", pulso_fim);
      end
   endtask

   task automatic test_down_wrap();
      m_val = 8'd12;
      desce = 1'b1;
      conta = 1'b1;
      step();
      assertions++;
      if (Q !== 8'd11) begin
         failures++;
         $display("FAIL down_wrap_q: got %0d expected 11", Q);
      end
      assertions++;
      if (pulso_fim !== 1'b1) begin
         failures++;
         $display("FAIL down_wrap_pulse: got %0b expected 1", pulso_fim);
      end
      for (int k = 1; k <= 11; k++) begin
         step();
         assertions++;
         if (Q !== 8'(11 - k) || pulso_fim !== 1'b0) begin
            failures++;
            $display("FAIL down_count: step %0d got Q=%0d p=%0b expected Q=%0d p=0",
                     k, Q, pulso_fim, 11 - k);
         end
      end
      conta = 1'b0;
      assertions++;
      if (fim !== 1'b1) begin
         failures++;
         $display("FAIL down_fim: got %0b expected 1", fim);
      end
   endtask

   task automatic test_priority();
      idle_inputs();
      desce   = 1'b0;
      m_val   = 8'd50;
      carrega = 1'b1;
      D       = 8'd30;
      step();
      assertions++;
      if (Q !== 8'd30) begin
         failures++;
         $display("FAIL load_q: got %0d expected 30", Q);
      end
      zera_s  = 1'b1;
      carrega = 1'b1;
      conta   = 1'b1;
      D       = 8'd5;
      step();
      assertions++;
      if (Q !== 8'd0 || pulso_fim !== 1'b0) begin
         failures++;
         $display("FAIL prio_clear: got Q=%0d p=%0b expected Q=0 p=0", Q, pulso_fim);
      end
      zera_s = 1'b0;
      D      = 8'd3;
      step();
      assertions++;
      if (Q !== 8'd3) begin
         failures++;
         $display("FAIL prio_load_over_count: got %0d expected 3", Q);
      end
      conta = 1'b0;
      D     = 8'd250;
      step();
      assertions++;
      if (Q !== 8'd49) begin
         failures++;
         $display("FAIL load_clamp: got %0d expected 49", Q);
      end
      idle_inputs();
   endtask

   task automatic test_runtime_shrink();
      idle_inputs();
      desce   = 1'b0;
      m_val   = '0;
      carrega = 1'b1;
      D       = 8'd39;
      step();
      carrega = 1'b0;
      conta   = 1'b1;
      step();
      conta = 1'b0;
      assertions++;
      if (Q !== 8'd40) begin
         failures++;
         $display("FAIL shrink_setup: got %0d expected 40", Q);
      end
      m_val = 8'd20;
      #1;
      assertions++;
      if (fim !== 1'b1) begin
         failures++;
         $display("FAIL shrink_fim_up: got %0b expected 1", fim);
      end
      conta = 1'b1;
      step();
      assertions++;
      if (Q !== 8'd0 || pulso_fim !== 1'b1) begin
         failures++;
         $display("FAIL shrink_up: got Q=%0d p=%0b expected Q=0 p=1", Q, pulso_fim);
      end
      conta   = 1'b0;
      m_val   = '0;
      carrega = 1'b1;
      D       = 8'd40;
      step();
      carrega = 1'b0;
      m_val   = 8'd20;
      desce   = 1'b1;
      conta   = 1'b1;
      step();
      assertions++;
      if (Q !== 8'd19 || pulso_fim !== 1'b0) begin
         failures++;
         $display("FAIL shrink_down: got Q=%0d p=%0b expected Q=19 p=0", Q, pulso_fim);
      end
      idle_inputs();
      desce = 1'b0;
   endtask

   task automatic test_flags();
      idle_inputs();
      m_val  = 8'd1;
      zera_s = 1'b1;
      step();
      zera_s = 1'b0;
      desce  = 1'b0;
      #1;
      assertions++;
      if (meio !== 1'b1 || fim !== 1'b1) begin
         failures++;
         $display("FAIL me1_flags_up: got meio=%0b fim=%0b expected 1 1", meio, fim);
      end
      desce = 1'b1;
      #1;
      assertions++;
      if (fim !== 1'b1) begin
         failures++;
         $display("FAIL me1_fim_down: got %0b expected 1", fim);
      end
      desce = 1'b0;
      conta = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         assertions++;
         if (Q !== 8'd0 || pulso_fim !== 1'b1) begin
            failures++;
            $display("FAIL me1_wrap: edge %0d got Q=%0d p=%0b expected Q=0 p=1",
                     k, Q, pulso_fim);
         end
      end
      conta = 1'b0;
      m_val = 8'd10;
      cmp   = 8'd7;
      step();
      for (int i = 0; i < 10; i++) begin
         assertions++;
         if (meio !== (i >= 4)) begin
            failures++;
            $display("FAIL meio_m10: Q=%0d got %0b expected %0b", i, meio, (i >= 4));
         end
         assertions++;
         if (iguala !== (i == 7)) begin
            failures++;
            $display("FAIL iguala_7: Q=%0d got %0b expected %0b", i, iguala, (i == 7));
         end
         conta = 1'b1;
         step();
         conta = 1'b0;
      end
      assertions++;
      if (Q !== 8'd0) begin
         failures++;
         $display("FAIL m10_wrap: got %0d expected 0", Q);
      end
      cmp = 8'd255;
   endtask

   task automatic test_async_reset();
      idle_inputs();
      m_val = '0;
      desce = 1'b0;
      conta = 1'b1;
      repeat (3) step();
      assertions++;
      if (Q !== 8'd3) begin
         failures++;
         $display("FAIL async_setup: got %0d expected 3", Q);
      end
      #2;
      zera_as_n = 1'b0;
      #1;
      assertions++;
      if (Q !== 8'd0 || pulso_fim !== 1'b0) begin
         failures++;
         $display("FAIL async_clear: got Q=%0d p=%0b expected Q=0 p=0", Q, pulso_fim);
      end
      step();
      zera_as_n = 1'b1;
      step();
      assertions++;
      if (Q !== 8'd1) begin
         failures++;
         $display("FAIL async_restart: got %0d expected 1", Q);
      end
      conta = 1'b0;
   endtask

   task automatic test_mode_m5();
      int pulses;
      int exp_pulses;
      int exp_up_q;
      idle_inputs();
`ifdef CONTADOR_M_UPDOWN_SATURA_EN
      exp_pulses = 0;
      exp_up_q   = 4;
`else
      exp_pulses = 2;
      exp_up_q   = 0;
`endif
      m_val  = 8'd5;
      zera_s = 1'b1;
      step();
      zera_s = 1'b0;
      desce  = 1'b0;
      conta  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pulso_fim === 1'b1) pulses++;
      end
      assertions++;
      if (Q !== 8'(exp_up_q)) begin
         failures++;
         $display("FAIL m5_up_q: got %0d expected %0d", Q, exp_up_q);
      end
      assertions++;
      if (pulses != exp_pulses) begin
         failures++;
         $display("FAIL m5_up_pulses: got %0d expected %0d", pulses, exp_pulses);
      end
      desce  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pulso_fim === 1'b1) pulses++;
      end
      assertions++;
      if (Q !== 8'd0) begin
         failures++;
         $display("FAIL m5_down_q: got %0d expected 0", Q);
      end
      assertions++;
      if (pulses != exp_pulses) begin
         failures++;
         $display("FAIL m5_down_pulses: got %0d expected %0d", pulses, exp_pulses);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_priority();
      test_runtime_shrink();
      test_flags();
      test_async_reset();
      test_mode_m5();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
